// File: rtl/rate_mult_decoder.sv
// rate_mult_decoder: recovers a binary-rate-multiplier control word from the encoder's Z pulse stream
// Ports: CK clock; RST sync active-high reset; EN phase step enable; Z_IN encoder pulse (sampled when EN);
//        SYNC window restart; C_OUT recovered word; C_VALID one-cycle strobe; C_ERR slot inconsistency;
//        PHASE current phase counter.
module rate_mult_decoder #(
  parameter int W = 16
) (
  input  logic         CK,
  input  logic         RST,
  input  logic         EN,
  input  logic         Z_IN,
  input  logic         SYNC,
  output logic [W-1:0] C_OUT,
  output logic         C_VALID,
  output logic         C_ERR,
  output logic [W-1:0] PHASE
);
  localparam logic [W-1:0] one = 1;
  logic [W-1:0] lz, slot, acc, seen0;
  // lz marks the lowest zero of PHASE; reversing it gives the owning bit k = W-1-t
  always_comb begin
    lz = ~PHASE & (PHASE + one);
    slot = '0;
    for (int i = 0; i < W; i++) slot[W-1-i] = lz[i];
  end
  always_ff @(posedge CK) begin
    if (RST) begin
      PHASE <= '0;
      C_OUT <= '0;
      C_VALID <= 1'b0;
      C_ERR <= 1'b0;
      acc <= '0;
      seen0 <= '0;
    end else begin
      C_VALID <= 1'b0;
      if (SYNC) begin
        PHASE <= '0;
        acc <= '0;
        seen0 <= '0;
      end else if (EN) begin
        PHASE <= PHASE + one;
        if (&PHASE) begin
          C_OUT <= acc;
          C_ERR <= |(acc & seen0) | Z_IN;
          C_VALID <= 1'b1;
          acc <= '0;
          seen0 <= '0;
        end else if (Z_IN) begin
          acc <= acc | slot;
        end else begin
          seen0 <= seen0 | slot;
        end
      end
    end
  end
endmodule

// File: tb/tb_rate_mult_decoder.sv
// tb_rate_mult_decoder: randomized and directed checks of rate_mult_decoder against a behavioural model
module tb_rate_mult_decoder;
  logic CK = 1'b0;
  logic RST, EN, Z_IN, SYNC;
  logic [3:0] C_OUT, PHASE;
  logic C_VALID, C_ERR;
  logic rst16, en16, z16, sync16;
  logic [15:0] c_out16, phase16;
  logic c_valid16, c_err16;
  int errors = 0;
  int checks = 0;
  int m_phase;
  bit m_one[4];
  bit m_zero[4];
  logic [15:0] m_cout;
  bit m_valid, m_err;

  always #5 CK = ~CK;

  rate_mult_decoder #(.W(4)) dut (
    .CK(CK), .RST(RST), .EN(EN), .Z_IN(Z_IN), .SYNC(SYNC),
    .C_OUT(C_OUT), .C_VALID(C_VALID), .C_ERR(C_ERR), .PHASE(PHASE)
  );

  rate_mult_decoder #(.W(16)) dut16 (
    .CK(CK), .RST(rst16), .EN(en16), .Z_IN(z16), .SYNC(sync16),
    .C_OUT(c_out16), .C_VALID(c_valid16), .C_ERR(c_err16), .PHASE(phase16)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int tones(input int n, input int w);
    int t = 0;
    while (t < w && ((n >> t) & 1) == 1) t++;
    return t;
  endfunction

  function automatic bit enc(input logic [15:0] c, input int n, input int w);
    int t = tones(n, w);
    return t < w ? c[w-1-t] : 1'b0;
  endfunction

  function automatic void clear_win();
    for (int k = 0; k < 4; k++) begin
      m_one[k] = 0;
      m_zero[k] = 0;
    end
  endfunction

  function automatic void model(input bit en, input bit z, input bit sync, input bit rst);
    m_valid = 0;
    if (rst) begin
      m_phase = 0;
      m_cout = 0;
      m_err = 0;
      clear_win();
    end else if (sync) begin
      m_phase = 0;
      clear_win();
    end else if (en) begin
      if (m_phase == 15) begin
        m_cout = 0;
        m_err = z;
        for (int k = 0; k < 4; k++) begin
          m_cout[k] = m_one[k];
          if (m_one[k] && m_zero[k]) m_err = 1;
        end
        m_valid = 1;
        clear_win();
        m_phase = 0;
      end else begin
        if (z) m_one[3 - tones(m_phase, 4)] = 1;
        else m_zero[3 - tones(m_phase, 4)] = 1;
        m_phase++;
      end
    end
  endfunction

  task automatic cyc(input bit en, input bit z, input bit sync, input bit rst);
    EN = en; Z_IN = z; SYNC = sync; RST = rst;
    @(posedge CK);
    model(en, z, sync, rst);
    #1;
    chk("phase", PHASE, m_phase);
    chk("valid", C_VALID, m_valid);
    chk("cout", C_OUT, m_cout);
    chk("cerr", C_ERR, m_err);
  endtask

  task automatic run_win(input logic [3:0] c, input bit toggle, input int bad_n, input bit bad_z, output int steps);
    steps = 0;
    do begin
      if (toggle && steps % 2 == 1) cyc(0, 1'($urandom_range(1)), 0, 0);
      else cyc(1, m_phase == bad_n ? bad_z : enc(c, m_phase, 4), 0, 0);
      steps++;
    end while (!m_valid && steps < 100);
    chk("win_timeout", steps < 100, 1);
  endtask

  initial begin
    int steps, vcount;
    logic [3:0] c;
    rst16 = 1; en16 = 0; z16 = 0; sync16 = 0;
    cyc(0, 0, 0, 1);
    run_win(4'b1010, 0, -1, 0, steps);
    chk("t1_latency", steps, 16);
    chk("t1_cout", C_OUT, 4'b1010);
    chk("t1_cerr", C_ERR, 0);
    run_win(4'b0000, 0, -1, 0, steps);
    chk("t2_cout0", C_OUT, 0);
    run_win(4'b1111, 0, -1, 0, steps);
    chk("t2_cout1", C_OUT, 4'b1111);
    chk("t2_steps", steps, 16);
    chk("t2_cerr", C_ERR, 0);
    run_win(4'b1000, 1, -1, 0, steps);
    chk("t3_latency", steps, 31);
    chk("t3_cout", C_OUT, 4'b1000);
    run_win(4'b0100, 0, 5, 0, steps);
    chk("t4_cout", C_OUT, 4'b0100);
    chk("t4_cerr", C_ERR, 1);
    run_win(4'b0100, 0, 15, 1, steps);
    chk("t4_cerr_last", C_ERR, 1);
    run_win(4'b0011, 0, -1, 0, steps);
    chk("t4_cerr_clear", C_ERR, 0);
    repeat (9) cyc(1, enc(4'b0110, m_phase, 4), 0, 0);
    cyc(1, 1, 1, 0);
    chk("t5_sync_phase", PHASE, 0);
    run_win(4'b0110, 0, -1, 0, steps);
    chk("t5_sync_steps", steps, 16);
    chk("t5_cout", C_OUT, 4'b0110);
    repeat (6) cyc(1, enc(4'b1001, m_phase, 4), 0, 0);
    cyc(1, 1, 1, 1);
    chk("t5_rst_cout", C_OUT, 0);
    chk("t5_rst_phase", PHASE, 0);
    for (int w = 0; w < 12; w++) begin
      c = 4'($urandom);
      run_win(c, 1'($urandom_range(1)), $urandom_range(40), 1'($urandom_range(1)), steps);
    end
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(3) != 0), 1'($urandom_range(1)), $urandom_range(30) == 0, $urandom_range(200) == 0);
    EN = 0; SYNC = 0; RST = 0;
    @(posedge CK); #1;
    rst16 = 0; en16 = 1;
    vcount = 0;
    for (int n = 0; n < 65536; n++) begin
      z16 = enc(16'hA5C3, n, 16);
      @(posedge CK); #1;
      if (c_valid16) vcount++;
    end
    chk("t6_valid_last", c_valid16, 1);
    chk("t6_vcount", vcount, 1);
    chk("t6_cout", c_out16, 16'hA5C3);
    chk("t6_cerr", c_err16, 0);
    chk("t6_phase", phase16, 0);
    en16 = 0;
    @(posedge CK); #1;
    chk("t6_valid_drop", c_valid16, 0);
    chk("t6_cout_hold", c_out16, 16'hA5C3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
